// File: rtl/reg_arbiter_pkg.sv
// Shared types and constants for the round-robin register arbiter.
package reg_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_WIDTH    = 16;
  localparam int DEF_MAX_HOLD = 4;

  // Ceiling log2, never less than 1 so index vectors are always legal.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dff_reg.sv
// Load-enabled register with asynchronous active-high clear.
module dff_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Per-bit DFF cells sharing one load enable.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    // Single-bit cell: clear on reset, capture d when enabled.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     q[b] <= 1'b0;
      else if (en) q[b] <= d[b];
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter granting exclusive write access to one shared register.
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       we,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [clog2(N_REQ)-1:0] owner,
  output logic                   busy,
  output logic [WIDTH-1:0]       q
);

  localparam int IW = clog2(N_REQ);
  localparam int HW = clog2(MAX_HOLD + 1);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [IW-1:0]    owner_nxt, ptr, ptr_nxt, win;
  logic [HW-1:0]    hold, hold_nxt;
  logic             win_vld, wr_en, armed;
  logic [WIDTH-1:0] wsel;

  assign busy = |gnt;

  // Round-robin search starting at ptr; N_REQ is a power of two so the
  // index addition wraps naturally.
  always_comb begin
    logic [IW-1:0] cand;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IW'(k);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Select the owner's write data slice.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (owner == IW'(i)) wsel = wdata[i*WIDTH +: WIDTH];
  end

  // Next-state, grant and hold-counter logic.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold;
    wr_en     = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        // armed blocks a grant on the first edge after reset release.
        if (armed && win_vld) begin
          state_nxt = OWN;
          gnt_nxt   = N_REQ'(1) << win;
          owner_nxt = win;
          ptr_nxt   = win + IW'(1);
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (!req[owner]) begin
          // Voluntary release: the write at this edge is dropped.
          state_nxt = IDLE;
          gnt_nxt   = '0;
          hold_nxt  = '0;
        end else begin
          wr_en = we[owner];
          if (hold == HW'(MAX_HOLD - 1)) begin
            // Last allowed cycle: write still lands, grant is revoked.
            state_nxt = IDLE;
            gnt_nxt   = '0;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold + HW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // State, grant, pointer and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= '0;
      hold  <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      hold  <= hold_nxt;
      armed <= 1'b1;
    end
  end

  dff_reg #(.WIDTH(WIDTH)) u_q (
    .clk (clk),
    .rst (rst),
    .en  (wr_en),
    .d   (wsel),
    .q   (q)
  );

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed self-checking bench for reg_arbiter (N_REQ=4, WIDTH=16, MAX_HOLD=4).
module tb_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, we;
  logic [63:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] q;
  int checks = 0;
  int errors = 0;

  reg_arbiter #(.N_REQ(4), .WIDTH(16), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .owner(owner), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wd(input int idx, input logic [15:0] v);
    wdata[idx*16 +: 16] = v;
  endtask

  // Continuous invariants: one-hot grant and busy tracking the grant.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (($countones(gnt) <= 1) && (busy === (|gnt))) else begin
        errors++;
        $error("FAIL onehot_busy: observed gnt=%b busy=%b expected one-hot and busy=|gnt", gnt, busy);
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; wdata = '0;
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);

    // Single requester with write.
    rst = 1'b0; req = 4'b0001; we = 4'b0001; set_wd(0, 16'h00A5);
    tick();
    chk("single_c1_gnt", 32'(gnt), 32'h0);
    tick();
    chk("single_c2_gnt", 32'(gnt), 32'h1);
    chk("single_c2_busy", 32'(busy), 32'h1);
    chk("single_c2_q", 32'(q), 32'h0);
    tick();
    chk("single_c3_q", 32'(q), 32'h00A5);
    chk("single_c3_gnt", 32'(gnt), 32'h1);
    req = '0; we = '0;
    tick();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_owner", 32'(owner), 32'h0);

    // Non-owner write ignored (ptr=1, only req0 so index 0 wins).
    req = 4'b0001; we = 4'b0010; set_wd(1, 16'hFFFF);
    tick();
    chk("nonown_gnt", 32'(gnt), 32'h1);
    tick();
    chk("nonown_q", 32'(q), 32'h00A5);
    req = '0; we = '0;
    tick();

    // Early release by owner 2 with a write on the release edge.
    req = 4'b0100;
    tick();
    chk("early_gnt", 32'(gnt), 32'h4);
    chk("early_owner", 32'(owner), 32'h2);
    tick();
    req = 4'b0000; we = 4'b0100; set_wd(2, 16'h1234);
    tick();
    chk("early_rel_gnt", 32'(gnt), 32'h0);
    chk("early_rel_q", 32'(q), 32'h00A5);
    req = 4'b0100; we = '0;
    tick();
    chk("early_regrant", 32'(gnt), 32'h4);

    // Asynchronous reset mid-grant, with a pending write.
    we = 4'b0100; set_wd(2, 16'hBEEF);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    rst = 1'b0; req = 4'b0110; we = '0;
    tick();
    chk("postrst_c1_gnt", 32'(gnt), 32'h0);
    tick();
    chk("postrst_c2_gnt", 32'(gnt), 32'h2);
    chk("postrst_q", 32'(q), 32'h0);
    req = '0;
    tick();

    // Wrap-around: grant 2 leaves ptr=3, then req=1001 wins 3 then 0.
    req = 4'b0100;
    tick();
    chk("wrap_pre_gnt", 32'(gnt), 32'h4);
    req = 4'b1001;
    tick();
    chk("wrap_rel_gnt", 32'(gnt), 32'h0);
    tick();
    chk("wrap_c1_gnt", 32'(gnt), 32'h8);
    tick();
    chk("wrap_c2_gnt", 32'(gnt), 32'h8);
    tick();
    chk("wrap_c3_gnt", 32'(gnt), 32'h8);
    tick();
    chk("wrap_c4_gnt", 32'(gnt), 32'h8);
    we = 4'b1000; set_wd(3, 16'h5A5A);
    tick();
    chk("forced_rel_gnt", 32'(gnt), 32'h0);
    chk("forced_rel_q", 32'(q), 32'h5A5A);
    we = '0;
    tick();
    chk("wrap_second_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();

    // Saturated round-robin from ptr=0.
    rst = 1'b1;
    #1;
    rst = 1'b0; req = 4'b1111;
    tick();
    tick();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("rr_g%0d_c%0d", g, c), 32'(gnt), 32'(1 << (g % 4)));
        tick();
      end
      chk($sformatf("rr_gap%0d", g), 32'(gnt), 32'h0);
      tick();
    end
    req = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
